// File: rtl/show_select_pkg.sv
// show_select_pkg: shared constants, action encoding and channel
// wrap helper for the show_select display selector.
package show_select_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NCH   = 4;
   localparam int DEF_SELW  = 2;
   localparam int DEF_DWELL = 50000000;
   localparam int DEF_CNTW  = 26;

   // What the selector does at the coming edge, highest priority first.
   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_STEP,
      ACT_AUTO,
      ACT_MANUAL
   } act_e;

   // Next channel index with wrap from nch-1 back to 0.
   function automatic int unsigned wrap_inc(
      input int unsigned ch,
      input int unsigned nch
   );
      return (ch + 1 >= nch) ? 0 : ch + 1;
   endfunction

endpackage

// File: rtl/show_dwell_timer.sv
// show_dwell_timer: auto-rotate dwell counter.
// Ports: clk, rst_n (sync, active-low), en (count), clr (restart),
//        tick (1-cycle pulse while the count sits at DWELL-1 and en=1).
module show_dwell_timer #(
   parameter int DWELL = 50000000,
   parameter int CNTW  = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNTW-1:0] LAST = CNTW'(DWELL - 1);

   logic [CNTW-1:0] cnt;

   assign tick = en & (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/show_select.sv
// show_select: registered NCH-way display selector, manual or auto-rotate,
// with step-button advance and freeze hold.
// Ports: clk, rst_n (sync, active-low), ch_data (NCH packed channels),
//        mode (0 manual / 1 auto), sel_in, step (button level), freeze;
//        out (selected data), cur_ch (shown index), sel_err (bad sel_in).
import show_select_pkg::*;

module show_select #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NCH   = DEF_NCH,
   parameter int SELW  = DEF_SELW,
   parameter int DWELL = DEF_DWELL,
   parameter int CNTW  = DEF_CNTW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH*WIDTH-1:0] ch_data,
   input  logic               mode,
   input  logic [SELW-1:0]    sel_in,
   input  logic               step,
   input  logic               freeze,
   output logic [WIDTH-1:0]   out,
   output logic [SELW-1:0]    cur_ch,
   output logic               sel_err
);

   logic            step_q;
   logic            step_rise;
   act_e            act;
   logic            tick;
   logic            tmr_en;
   logic            tmr_clr;
   logic            sel_ok;
   logic [SELW-1:0] inc_ch;
   logic [SELW-1:0] nxt;
   logic            nxt_err;
   logic [WIDTH-1:0] nxt_data;

   assign step_rise = step & ~step_q;

   // Conditions are made mutually exclusive so the decoder is one-hot.
   always_comb begin
      act = ACT_MANUAL;
      unique case (1'b1)
         freeze:                          act = ACT_HOLD;
         (!freeze && step_rise):          act = ACT_STEP;
         (!freeze && !step_rise && mode): act = ACT_AUTO;
         default:                         act = ACT_MANUAL;
      endcase
   end

   // The dwell count freezes with the display and restarts on any
   // manual cycle or step, so auto mode always begins with a full dwell.
   assign tmr_en  = (act == ACT_AUTO);
   assign tmr_clr = (act == ACT_STEP) || (act == ACT_MANUAL);

   show_dwell_timer #(
      .DWELL (DWELL),
      .CNTW  (CNTW)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tmr_en),
      .clr   (tmr_clr),
      .tick  (tick)
   );

   assign sel_ok = (32'(sel_in) < NCH);
   assign inc_ch = SELW'(wrap_inc(32'(cur_ch), NCH));

   always_comb begin
      nxt     = cur_ch;
      nxt_err = sel_err;
      unique case (act)
         ACT_HOLD: begin
            nxt     = cur_ch;
            nxt_err = sel_err;
         end
         ACT_STEP: begin
            nxt     = inc_ch;
            nxt_err = 1'b0;
         end
         ACT_AUTO: begin
            if (tick) begin
               nxt = inc_ch;
            end
         end
         ACT_MANUAL: begin
            nxt     = sel_ok ? sel_in : '0;
            nxt_err = ~sel_ok;
         end
         default: begin
            nxt     = cur_ch;
            nxt_err = sel_err;
         end
      endcase
   end

   assign nxt_data = ch_data[32'(nxt)*WIDTH +: WIDTH];

   // step_q tracks the button even through reset and freeze, so a
   // button already held when either ends is not a fresh press.
   always_ff @(posedge clk) begin
      step_q <= step;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out     <= '0;
         cur_ch  <= '0;
         sel_err <= 1'b0;
      end else if (act != ACT_HOLD) begin
         out     <= nxt_data;
         cur_ch  <= nxt;
         sel_err <= nxt_err;
      end
   end

endmodule

// File: tb/tb_show_select.sv
// tb_show_select: scoreboard bench for show_select (NCH=4 and NCH=3 builds,
// DWELL=4); expectations queued at stimulus, checked after each edge.
module tb_show_select;

   logic        clk;
   logic        rst_n;
   logic [63:0] ch_data;
   logic        mode;
   logic [1:0]  sel_in;
   logic        step;
   logic        freeze;
   logic [15:0] out;
   logic [1:0]  cur_ch;
   logic        sel_err;

   logic [47:0] ch_data3;
   logic [1:0]  sel3;
   logic        step3;
   logic [15:0] out3;
   logic [1:0]  cur_ch3;
   logic        sel_err3;

   int tests = 0;
   int fails = 0;

   logic [15:0] val [4];

   typedef struct {
      string       name;
      bit          c4;
      logic [15:0] o4;
      logic [1:0]  ch4;
      logic        e4;
      bit          c3;
      logic [15:0] o3;
      logic [1:0]  ch3;
      logic        e3;
   } exp_t;

   exp_t q[$];

   show_select #(
      .WIDTH(16), .NCH(4), .SELW(2), .DWELL(4), .CNTW(26)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .mode(mode),
      .sel_in(sel_in), .step(step), .freeze(freeze),
      .out(out), .cur_ch(cur_ch), .sel_err(sel_err)
   );

   show_select #(
      .WIDTH(16), .NCH(3), .SELW(2), .DWELL(4), .CNTW(26)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .ch_data(ch_data3), .mode(1'b0),
      .sel_in(sel3), .step(step3), .freeze(1'b0),
      .out(out3), .cur_ch(cur_ch3), .sel_err(sel_err3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end, want finish");
      $fatal(1, "timeout");
   end

   // Monitor: each edge consumes the expectation queued before it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.c4) begin
               tests++;
               if (out !== e.o4 || cur_ch !== e.ch4 || sel_err !== e.e4) begin
                  fails++;
                  $display("FAIL %s: got out=%h ch=%0d err=%b, want out=%h ch=%0d err=%b",
                           e.name, out, cur_ch, sel_err, e.o4, e.ch4, e.e4);
               end
            end
            if (e.c3) begin
               tests++;
               if (out3 !== e.o3 || cur_ch3 !== e.ch3 || sel_err3 !== e.e3) begin
                  fails++;
                  $display("FAIL %s: got out=%h ch=%0d err=%b, want out=%h ch=%0d err=%b",
                           e.name, out3, cur_ch3, sel_err3, e.o3, e.ch3, e.e3);
               end
            end
         end
      end
   end

   task automatic tk(input string n, input bit c4, input logic [15:0] o4,
                     input logic [1:0] ch4, input logic e4, input bit c3,
                     input logic [15:0] o3, input logic [1:0] ch3,
                     input logic e3);
      exp_t e;
      e = '{n, c4, o4, ch4, e4, c3, o3, ch3, e3};
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic t(input string n, input logic [15:0] o,
                    input logic [1:0] ch, input logic err);
      tk(n, 1'b1, o, ch, err, 1'b0, 16'h0, 2'd0, 1'b0);
   endtask

   task automatic t3(input string n, input logic [15:0] o,
                     input logic [1:0] ch, input logic err);
      tk(n, 1'b0, 16'h0, 2'd0, 1'b0, 1'b1, o, ch, err);
   endtask

   initial begin
      int c;
      val[0] = 16'hAAAA;
      val[1] = 16'hBBBB;
      val[2] = 16'hCCCC;
      val[3] = 16'hDDDD;
      ch_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
      ch_data3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
      rst_n  = 1'b0;
      mode   = 1'b0;
      sel_in = 2'd0;
      step   = 1'b0;
      freeze = 1'b0;
      sel3   = 2'd0;
      step3  = 1'b0;
      @(negedge clk);

      t("reset_a", 16'h0, 2'd0, 1'b0);
      t("reset_b", 16'h0, 2'd0, 1'b0);
      rst_n = 1'b1;
      t("man_ch0", 16'hAAAA, 2'd0, 1'b0);

      sel_in = 2'd2;
      t("man_ch2", 16'hCCCC, 2'd2, 1'b0);
      ch_data[47:32] = 16'h1234;
      t("live_data", 16'h1234, 2'd2, 1'b0);
      ch_data[47:32] = 16'hCCCC;
      t("live_back", 16'hCCCC, 2'd2, 1'b0);
      sel_in = 2'd0;
      t("man_back0", 16'hAAAA, 2'd0, 1'b0);

      mode = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         c = (e / 4) % 4;
         t($sformatf("auto_%0d", e), val[c], 2'(c), 1'b0);
      end

      step = 1'b1;
      t("step_adv", 16'hCCCC, 2'd2, 1'b0);
      step = 1'b0;
      t("step_dw1", 16'hCCCC, 2'd2, 1'b0);
      t("step_dw2", 16'hCCCC, 2'd2, 1'b0);
      t("step_dw3", 16'hCCCC, 2'd2, 1'b0);
      t("step_dw4", 16'hDDDD, 2'd3, 1'b0);

      step = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         c = (j - 1) / 4;
         t($sformatf("held_%0d", j), val[c], 2'(c), 1'b0);
      end
      step = 1'b0;
      t("rel_1", 16'hCCCC, 2'd2, 1'b0);
      t("rel_2", 16'hCCCC, 2'd2, 1'b0);
      t("rel_3", 16'hDDDD, 2'd3, 1'b0);

      freeze = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step = (j == 5);
         t($sformatf("frz_%0d", j), 16'hDDDD, 2'd3, 1'b0);
      end
      freeze = 1'b0;
      step   = 1'b0;
      t("unfrz_1", 16'hDDDD, 2'd3, 1'b0);
      t("unfrz_2", 16'hDDDD, 2'd3, 1'b0);
      t("unfrz_3", 16'hDDDD, 2'd3, 1'b0);
      t("unfrz_4", 16'hAAAA, 2'd0, 1'b0);

      for (int j = 1; j <= 9; j++) begin
         c = (j >= 8) ? 2 : j / 4;
         t($sformatf("pre_rst_%0d", j), val[c], 2'(c), 1'b0);
      end
      rst_n = 1'b0;
      step  = 1'b1;
      t("mid_rst", 16'h0, 2'd0, 1'b0);
      rst_n = 1'b1;
      t("post_rst_1", 16'hAAAA, 2'd0, 1'b0);
      t("post_rst_2", 16'hAAAA, 2'd0, 1'b0);
      t("post_rst_3", 16'hAAAA, 2'd0, 1'b0);
      t("post_rst_4", 16'hBBBB, 2'd1, 1'b0);

      mode   = 1'b0;
      step   = 1'b0;
      sel_in = 2'd1;
      t("man_ch1", 16'hBBBB, 2'd1, 1'b0);
      step = 1'b1;
      t("man_step", 16'hCCCC, 2'd2, 1'b0);
      step = 1'b0;
      t("man_after", 16'hBBBB, 2'd1, 1'b0);

      sel3 = 2'd3;
      t3("n3_bad", 16'hAAAA, 2'd0, 1'b1);
      sel3 = 2'd2;
      t3("n3_ch2", 16'hCCCC, 2'd2, 1'b0);
      sel3  = 2'd3;
      step3 = 1'b1;
      t3("n3_wrap", 16'hAAAA, 2'd0, 1'b0);
      step3 = 1'b0;
      t3("n3_bad2", 16'hAAAA, 2'd0, 1'b1);
      step3 = 1'b1;
      t3("n3_step", 16'hBBBB, 2'd1, 1'b0);
      step3 = 1'b0;
      t3("n3_bad3", 16'hAAAA, 2'd0, 1'b1);

      @(posedge clk);
      #3;
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
